// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL bit positions and reset values.
package timer_pkg;

    // Byte offsets of the timer registers within the 32-byte window
    typedef enum logic [4:0] {
        MTIME_LO_OFF    = 5'h00,
        MTIME_HI_OFF    = 5'h04,
        MTIMECMP_LO_OFF = 5'h08,
        MTIMECMP_HI_OFF = 5'h0C,
        TIMER_CTRL_OFF  = 5'h10
    } type_timer_addr;

    // CTRL register layout
    localparam int CTRL_W          = 2;
    localparam int CTRL_CNT_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Compare register resets to the maximum so no interrupt fires out of reset
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // CTRL read-back: unimplemented bits read as zero
    function automatic logic [31:0] ctrl_readback(input logic [CTRL_W-1:0] ctrl);
        return {{(32 - CTRL_W){1'b0}}, ctrl};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the machine timer: emits a one-cycle tick every PRESCALE
// enabled cycles. Disabling freezes the count where it is.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    // Advance the count while enabled, wrapping on the tick cycle
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mtimer_irq_gen.sv
// RISC-V machine timer peripheral: 64-bit mtime, 64-bit mtimecmp and a CTRL
// register on a simple single-cycle bus; drives the CSR interrupt input.
// Build option: define MTIMER_IRQ_PULSE_EN to turn timer_irq into a
// single-cycle pulse on each rising edge of the compare condition instead of
// a level.
module mtimer_irq_gen
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        timer_irq
);

    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       mtimecmp_q, mtimecmp_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              irq_q, irq_d;
    logic              irq_cond;

    logic        sel;
    logic        rd_acc;
    logic        wr_acc;
    logic [4:0]  offset;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic [31:0] rd_mux;
    logic        tick;
    logic [63:0] mtime_inc;

    assign offset = bus_addr[4:0];
    assign sel    = bus_req && (bus_addr[31:5] == BASE_ADDR[31:5]);
    assign rd_acc = sel && !bus_we;
    assign wr_acc = sel && bus_we;

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (ctrl_q[CTRL_CNT_EN_BIT]),
        .tick(tick)
    );

    // Decode write strobes and the read-data mux from the register offset
    always_comb begin
        wr_mtime_lo = 1'b0;
        wr_mtime_hi = 1'b0;
        wr_cmp_lo   = 1'b0;
        wr_cmp_hi   = 1'b0;
        wr_ctrl     = 1'b0;
        rd_mux      = '0;
        case (offset)
            MTIME_LO_OFF: begin
                wr_mtime_lo = wr_acc;
                rd_mux      = mtime_q[31:0];
            end
            MTIME_HI_OFF: begin
                wr_mtime_hi = wr_acc;
                rd_mux      = mtime_q[63:32];
            end
            MTIMECMP_LO_OFF: begin
                wr_cmp_lo = wr_acc;
                rd_mux    = mtimecmp_q[31:0];
            end
            MTIMECMP_HI_OFF: begin
                wr_cmp_hi = wr_acc;
                rd_mux    = mtimecmp_q[63:32];
            end
            TIMER_CTRL_OFF: begin
                wr_ctrl = wr_acc;
                rd_mux  = ctrl_readback(ctrl_q);
            end
            default: begin
                rd_mux = '0;
            end
        endcase
    end

    // Next register state: counting, with a bus write owning the half it targets.
    // Writing LO drops any carry into HI; writing HI keeps the LO increment.
    always_comb begin
        mtime_inc  = mtime_q + {63'd0, tick};
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], bus_wdata};
        end
        if (wr_mtime_hi) begin
            mtime_d = {bus_wdata, mtime_inc[31:0]};
        end
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = bus_wdata;
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = bus_wdata;
        end
        if (wr_ctrl) begin
            ctrl_d = bus_wdata[CTRL_W-1:0];
        end
    end

    // Read response: capture the pre-update value, hold it between reads
    always_comb begin
        rvalid_d = rd_acc;
        rdata_d  = rd_acc ? rd_mux : rdata_q;
    end

    assign irq_cond = ctrl_q[CTRL_IRQ_EN_BIT] && (mtime_q >= mtimecmp_q);

`ifdef MTIMER_IRQ_PULSE_EN
    logic cond_q;

    // Pulse on the rising edge of the compare condition only
    always_comb begin
        irq_d = irq_cond && !cond_q;
    end

    // Registered copy of the condition level for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            cond_q <= 1'b0;
        end else begin
            cond_q <= irq_cond;
        end
    end
`else
    // Level interrupt follows the compare condition with one cycle latency
    always_comb begin
        irq_d = irq_cond;
    end
`endif

    // Architectural registers and bus/interrupt outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            ctrl_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign timer_irq  = irq_q;

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// Self-checking bench for mtimer_irq_gen: directed literal checks plus a
// randomized bus workload compared every cycle against a behavioural model.
module tb_mtimer_irq_gen;

    localparam int unsigned P    = 4;
    localparam logic [31:0] BASE = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        timer_irq;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mtimer_irq_gen #(
        .PRESCALE (P),
        .BASE_ADDR(BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .timer_irq (timer_irq)
    );

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime, m_cmp;
    logic [1:0]  m_ctrl;
    int          m_pcnt;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_irq, m_prev;

    function automatic logic [31:0] model_read(input logic [4:0] off);
        case (off)
            5'h00:   return m_mtime[31:0];
            5'h04:   return m_mtime[63:32];
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return {30'd0, m_ctrl};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit          hit, tick, cond;
        logic [63:0] nxt;
        if (!rst) begin
            m_mtime  <= 64'd0;
            m_cmp    <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_ctrl   <= 2'd0;
            m_pcnt   <= 0;
            m_rdata  <= 32'd0;
            m_rvalid <= 1'b0;
            m_irq    <= 1'b0;
            m_prev   <= 1'b0;
        end else begin
            hit  = bus_req && (bus_addr[31:5] == BASE[31:5]);
            cond = m_ctrl[1] && (m_mtime >= m_cmp);
`ifdef MTIMER_IRQ_PULSE_EN
            m_irq <= cond && !m_prev;
`else
            m_irq <= cond;
`endif
            m_prev   <= cond;
            m_rvalid <= hit && !bus_we;
            if (hit && !bus_we) m_rdata <= model_read(bus_addr[4:0]);
            tick = m_ctrl[0] && (m_pcnt == int'(P) - 1);
            if (m_ctrl[0]) m_pcnt <= tick ? 0 : m_pcnt + 1;
            nxt = m_mtime + (tick ? 64'd1 : 64'd0);
            if (hit && bus_we) begin
                case (bus_addr[4:0])
                    5'h00: nxt = {m_mtime[63:32], bus_wdata};
                    5'h04: nxt = {bus_wdata, nxt[31:0]};
                    5'h08: m_cmp <= {m_cmp[63:32], bus_wdata};
                    5'h0C: m_cmp <= {bus_wdata, m_cmp[31:0]};
                    5'h10: m_ctrl <= bus_wdata[1:0];
                    default: ;
                endcase
            end
            m_mtime <= nxt;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model rvalid", {63'd0, bus_rvalid}, {63'd0, m_rvalid});
            check("model rdata", {32'd0, bus_rdata}, {32'd0, m_rdata});
            check("model irq", {63'd0, timer_irq}, {63'd0, m_irq});
        end
    end

    // ---------------- bus tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] data);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = BASE | {27'd0, off};
        bus_wdata = data;
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        bus_we  = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] off, input logic [31:0] exp);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = BASE | {27'd0, off};
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        check({name, " rvalid"}, {63'd0, bus_rvalid}, 64'd1);
        check(name, {32'd0, bus_rdata}, {32'd0, exp});
    endtask

    task automatic do_reset();
        bus_req = 1'b0;
        bus_we  = 1'b0;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    int rises, highs;
    logic prev_irq;

    initial begin
        // Reset state
        do_reset();
        checking = 1'b1;
        check("reset irq", {63'd0, timer_irq}, 64'd0);
        check("reset rvalid", {63'd0, bus_rvalid}, 64'd0);
        check("reset rdata", {32'd0, bus_rdata}, 64'd0);
        rd_check("reset mtime_lo", 5'h00, 32'd0);
        rd_check("reset mtime_hi", 5'h04, 32'd0);
        rd_check("reset cmp_lo", 5'h08, 32'hFFFF_FFFF);
        rd_check("reset cmp_hi", 5'h0C, 32'hFFFF_FFFF);
        rd_check("reset ctrl", 5'h10, 32'd0);
        rd_check("unmapped read", 5'h14, 32'd0);

        // Prescaled counting and freeze
        do_reset();
        wr(5'h10, 32'd1);
        idle(40);
        wr(5'h10, 32'd0);
        rd_check("count 40 cycles", 5'h00, 32'd10);
        idle(20);
        rd_check("count frozen", 5'h00, 32'd10);
        rd_check("count hi", 5'h04, 32'd0);

        // Carry LO -> HI
        do_reset();
        wr(5'h04, 32'd0);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'd1);
        idle(5);
        wr(5'h10, 32'd0);
        rd_check("carry lo", 5'h00, 32'd0);
        rd_check("carry hi", 5'h04, 32'd1);

        // Full 64-bit wrap
        do_reset();
        wr(5'h04, 32'hFFFF_FFFF);
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'd1);
        idle(5);
        wr(5'h10, 32'd0);
        rd_check("wrap lo", 5'h00, 32'd0);
        rd_check("wrap hi", 5'h04, 32'd0);

        // Interrupt timing
        do_reset();
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd20);
        wr(5'h10, 32'd3);
        idle(80);
        check("irq before match", {63'd0, timer_irq}, 64'd0);
        idle(1);
        check("irq after match", {63'd0, timer_irq}, 64'd1);
        idle(1);
`ifdef MTIMER_IRQ_PULSE_EN
        check("irq pulse ends", {63'd0, timer_irq}, 64'd0);
`else
        check("irq level holds", {63'd0, timer_irq}, 64'd1);
`endif
        wr(5'h08, 32'd100);
        idle(1);
        check("irq drop on cmp raise", {63'd0, timer_irq}, 64'd0);
        wr(5'h08, 32'd20);
        idle(1);
        check("irq re-rise", {63'd0, timer_irq}, 64'd1);
        wr(5'h10, 32'd1);
        idle(1);
        check("irq drop on irq_en clear", {63'd0, timer_irq}, 64'd0);

        // Write/tick collision on LO
        do_reset();
        wr(5'h10, 32'd1);
        idle(3);
        wr(5'h00, 32'd5);
        wr(5'h10, 32'd0);
        rd_check("collision lo", 5'h00, 32'd5);

        // Write/tick collision on HI with LO about to wrap
        do_reset();
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h10, 32'd1);
        idle(3);
        wr(5'h04, 32'd7);
        wr(5'h10, 32'd0);
        rd_check("collision hi", 5'h04, 32'd7);
        rd_check("collision hi lo", 5'h00, 32'd0);

        // Edge count across a held condition and a re-match
        do_reset();
        wr(5'h0C, 32'd0);
        wr(5'h08, 32'd4);
        wr(5'h10, 32'd3);
        rises = 0;
        highs = 0;
        prev_irq = 1'b0;
        for (int i = 0; i < 160; i++) begin
            if (i == 60) begin
                wr(5'h08, 32'd30);
            end else begin
                idle(1);
            end
            if (timer_irq && !prev_irq) rises++;
            if (timer_irq) highs++;
            prev_irq = timer_irq;
        end
        check("irq rising edges", 64'(rises), 64'd2);
`ifdef MTIMER_IRQ_PULSE_EN
        check("irq pulse cycles", 64'(highs), 64'd2);
`endif

        // Randomized workload against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int k;
            int w;
            rst     = ($urandom_range(0, 299) != 0);
            bus_req = ($urandom_range(0, 99) < 60);
            bus_we  = $urandom_range(0, 1) == 1;
            k = $urandom_range(0, 9);
            case (k)
                5:       bus_addr = BASE | 32'h14;
                6:       bus_addr = BASE | 32'h1C;
                7:       bus_addr = (BASE + 32'h20) | {27'd0, 5'($urandom_range(0, 4) * 4)};
                8, 9:    bus_addr = BASE | 32'h10;
                default: bus_addr = BASE | 32'(k * 4);
            endcase
            w = $urandom_range(0, 3);
            case (w)
                0:       bus_wdata = $urandom;
                1:       bus_wdata = 32'hFFFF_FFFF;
                2:       bus_wdata = $urandom_range(0, 40);
                default: bus_wdata = 32'd0;
            endcase
            if (bus_addr[4:0] == 5'h10 && $urandom_range(0, 3) != 0) bus_wdata = 32'd3;
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        bus_req = 1'b0;
        idle(4);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
